// File: rtl/ntt_out_collector.sv
// Collects NTT output coefficients into {odd, even} 32-bit words through a small FWFT FIFO,
// and keeps a per-frame mod-Q checksum plus an out-of-range flag.
module ntt_out_collector #(
  parameter int N_COEF     = 128,
  parameter int Q          = 12289,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        frame_done,
  output logic [13:0] frame_sum,
  output logic        frame_err,
  output logic        overflow
);

  localparam int IW = $clog2(N_COEF);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_COEF - 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [15:0]   Q_IN     = 16'(Q);
  localparam logic [14:0]   Q_SUM    = 15'(Q);

  // Handshake: in_valid is never stalled; an output word moves when out_valid && out_ready
  // at a rising edge, and out_data is held while out_valid=1 and out_ready=0.
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   idx;
  logic [15:0]     even_q;
  logic [13:0]     acc, acc_base, acc_next;
  logic            err, err_base, err_next;
  logic [14:0]     sum_wide;
  logic            coef_bad, last_coef, push, pop, full, push_ok;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  assign coef_bad   = in_data >= Q_IN;
  assign last_coef  = in_valid && (idx == LAST_IDX);
  assign push       = in_valid && idx[0];
  assign full       = (count == FULL_CNT);
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still take the word.
  assign push_ok    = push && (!full || pop);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign frame_done = (state == DONE);

  // The DONE cycle starts a fresh frame, so a coefficient arriving there accumulates from zero.
  always_comb begin
    acc_base = (state == DONE) ? '0 : acc;
    err_base = (state == DONE) ? 1'b0 : err;
    sum_wide = {1'b0, acc_base} + (coef_bad ? 15'd0 : in_data[14:0]);
    acc_next = acc_base;
    err_next = err_base;
    if (in_valid) begin
      err_next = err_base | coef_bad;
      acc_next = (sum_wide >= Q_SUM) ? 14'(sum_wide - Q_SUM) : sum_wide[13:0];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = COLLECT;
      COLLECT: if (last_coef) state_next = DONE;
      DONE:    state_next = in_valid ? COLLECT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      even_q    <= '0;
      acc       <= '0;
      err       <= 1'b0;
      frame_sum <= '0;
      frame_err <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      err   <= err_next;
      if (in_valid) begin
        idx <= last_coef ? '0 : idx + 1'b1;
        if (!idx[0]) even_q <= in_data;
      end
      if (state == DONE) begin
        frame_sum <= acc;
        frame_err <= err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {in_data, even_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)     rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule
